square_checker: RTL and testbench
=================================

# square_checker

Sequential verifier for the square-root finder: given a radicand and a candidate root, it computes the candidate's square with a shift-add squarer and reports whether the candidate is the exact or floor square root, too low, or too high. It is the reverse direction of the root search: it squares rather than roots. It sits downstream of the root estimator and refinement stages and gives them a pass/fail and direction signal on a start/done handshake.

## Interface
- IN_W, 20, radicand width
- ROOT_W, 10, candidate root width (IN_W/2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; accepted only when busy=0
- valIn  in  IN_W  radicand, captured on accepted start
- rootIn  in  ROOT_W  candidate root, captured on accepted start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, results valid
- square  out  2*ROOT_W  rootIn², held until next accepted start
- isExact  out  1  square == valIn
- isFloor  out  1  square <= valIn < (rootIn+1)²
- tooLow  out  1  (rootIn+1)² <= valIn
- tooHigh  out  1  square > valIn
- resid  out  IN_W+1  signed valIn − square; present only with SQUARE_CHECKER_RESID_EN

## Operation
- FSM states: IDLE, SQUARE, CHECK, DONE.
- IDLE: on start=1, latch valIn and rootIn. Clear acc (2*ROOT_W+2 bits), set mcand = zero-extended root, set mplier = root, set bit counter to 0, then go to SQUARE.
- SQUARE: once per cycle, if mplier[0]=1 then acc += mcand; then mcand <<= 1, mplier >>= 1, counter++. Exit to CHECK after exactly ROOT_W iterations. No early termination, so latency is fixed.
- CHECK: nxt = acc + (root<<1) + 1, which is (root+1)², width 2*ROOT_W+2. Compute flags from acc and nxt against zero-extended valIn, then register square, the flags and resid. Go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Exactly one of tooLow, tooHigh, isFloor is 1 after any completed check. isExact implies isFloor.
- start while busy=1 is ignored and causes no queued request.
- Arithmetic is unsigned throughout except resid, which is two's complement of width IN_W+1.

## Timing
- Accepted start at cycle 0: SQUARE occupies cycles 1..ROOT_W, CHECK is cycle ROOT_W+1, done=1 at cycle ROOT_W+2 (12 with the defaults).
- busy=1 on cycles 1..ROOT_W+2. A new start is accepted from cycle ROOT_W+3.
- Outputs change only on the CHECK→DONE edge and hold until the next result or reset.
- Reset (rst_n=0 at a clock edge), including mid-operation: state goes to IDLE. busy, done, square, all flags and resid go to 0, and any in-flight request is discarded.
- start asserted in the same cycle rst_n=0 is ignored.

## Configuration
- SQUARE_CHECKER_RESID_EN defined: the resid port and register exist. resid = valIn − rootIn², registered in CHECK.
- Not defined: the port and logic are absent, and all other behaviour and latency are identical.

## Structure
- Package sqrt_pkg holds:
  - the state enum (IDLE, SQUARE, CHECK, DONE)
  - default width constants IN_W_DEF=20 and ROOT_W_DEF=10
  - the flag bit-order constant, shared with the refinement stage.
- One sub-module, square_core, is natural: the shift-add datapath (acc, mcand, mplier, counter), with load/step inputs and a last output. The top level holds the FSM, the compare logic and the output registers.

## Test plan
- valIn=100, rootIn=10 → done at cycle 12, square=100, isExact=1, isFloor=1, tooLow=0, tooHigh=0, resid=0.
- valIn=99, rootIn=9 → square=81, isFloor=1, isExact=0, resid=18. With rootIn=10 → tooHigh=1, resid=−1.
- valIn=1048575, rootIn=1023 → square=1046529, isFloor=1 ((r+1)²=1048576 needs the widened nxt). valIn=0, rootIn=0 → isExact=1.
- valIn=50, rootIn=3 → square=9, tooLow=1. start pulsed again at cycles 3 and 11 → ignored, single done, results unchanged.
- rst_n=0 at cycle 5 of an operation → next cycle busy=0, all outputs 0, no done. A new start then completes normally 12 cycles later.
- Back-to-back: start at cycle 13 right after a done → accepted, done at cycle 25. Exhaustive sweep of rootIn 0..1023 against a model at valIn=rootIn² and rootIn²−1 → exactly one of tooLow, tooHigh, isFloor set in every case.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root finder family: FSM state encoding,
// default widths and the flag bit order agreed with the refinement stage.
package sqrt_pkg;

    localparam int IN_W_DEF   = 20;
    localparam int ROOT_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } sqState_e;

    // Flag bit order inside a packed flag word; the refinement stage decodes
    // the same positions, so keep these in sync with it.
    localparam int FLAG_EXACT = 0;
    localparam int FLAG_FLOOR = 1;
    localparam int FLAG_LOW   = 2;
    localparam int FLAG_HIGH  = 3;
    localparam int FLAG_W     = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    // Assemble the individual comparison results into the shared flag word.
    function automatic flags_t packFlags(input logic exact, input logic floorOk,
                                         input logic low, input logic high);
        flags_t f;
        f             = '0;
        f[FLAG_EXACT] = exact;
        f[FLAG_FLOOR] = floorOk;
        f[FLAG_LOW]   = low;
        f[FLAG_HIGH]  = high;
        return f;
    endfunction

endpackage

// File: rtl/square_checker_if.sv
// Request/result bundle between the root refinement stages (master) and the
// square checker (slave). The resid signal exists only when
// SQUARE_CHECKER_RESID_EN is defined.
interface square_checker_if
    import sqrt_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int ROOT_W = ROOT_W_DEF
);
    logic                  start;
    logic [IN_W-1:0]       valIn;
    logic [ROOT_W-1:0]     rootIn;
    logic                  busy;
    logic                  done;
    logic [2*ROOT_W-1:0]   square;
    logic                  isExact;
    logic                  isFloor;
    logic                  tooLow;
    logic                  tooHigh;
`ifdef SQUARE_CHECKER_RESID_EN
    logic signed [IN_W:0]  resid;

    modport master (
        output start, valIn, rootIn,
        input  busy, done, square, isExact, isFloor, tooLow, tooHigh, resid
    );

    modport slave (
        input  start, valIn, rootIn,
        output busy, done, square, isExact, isFloor, tooLow, tooHigh, resid
    );
`else
    modport master (
        output start, valIn, rootIn,
        input  busy, done, square, isExact, isFloor, tooLow, tooHigh
    );

    modport slave (
        input  start, valIn, rootIn,
        output busy, done, square, isExact, isFloor, tooLow, tooHigh
    );
`endif

endinterface

// File: rtl/square_core.sv
// Shift-add squarer datapath: load captures the root, each step consumes one
// multiplier bit, last flags the final step of a fixed ROOT_W-step run.
module square_core #(
    parameter  int ROOT_W = 10,
    localparam int ACC_W  = 2*ROOT_W + 2,
    localparam int CNT_W  = $clog2(ROOT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ROOT_W-1:0] rootIn,
    output logic [ACC_W-1:0]  acc,
    output logic              last
);

    logic [ACC_W-1:0]  accR;
    logic [ACC_W-1:0]  mcandR;
    logic [ROOT_W-1:0] mplierR;
    logic [CNT_W-1:0]  cntR;

    // Load the operands or advance the shift-add by one multiplier bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accR    <= '0;
            mcandR  <= '0;
            mplierR <= '0;
            cntR    <= '0;
        end else if (load) begin
            accR    <= '0;
            mcandR  <= {{(ACC_W-ROOT_W){1'b0}}, rootIn};
            mplierR <= rootIn;
            cntR    <= '0;
        end else if (step) begin
            if (mplierR[0]) begin
                accR <= accR + mcandR;
            end
            mcandR  <= mcandR << 1;
            mplierR <= mplierR >> 1;
            cntR    <= cntR + CNT_W'(1);
        end
    end

    // The step taken while the counter reads ROOT_W-1 is the last one.
    always_comb begin
        last = (cntR == CNT_W'(ROOT_W - 1));
    end

    assign acc = accR;

endmodule

// File: rtl/square_checker.sv
// Square checker: squares a candidate root with square_core and classifies it
// against the radicand as exact/floor root, too low or too high.
// Optional feature macro: SQUARE_CHECKER_RESID_EN adds the signed residual.
module square_checker
    import sqrt_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int ROOT_W = ROOT_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    square_checker_if.slave bus
);

    localparam int ACC_W = 2*ROOT_W + 2;

    sqState_e          stateR;
    sqState_e          nextStateS;
    logic              loadS;
    logic              stepS;
    logic              lastS;
    logic [ACC_W-1:0]  accS;

    logic [IN_W-1:0]   valR;
    logic [ROOT_W-1:0] rootR;

    logic [ACC_W-1:0]  valExtS;
    logic [ACC_W-1:0]  nxtS;
    flags_t            flagsS;

    logic                busyR;
    logic                doneR;
    logic [2*ROOT_W-1:0] squareR;
    flags_t              flagsR;
`ifdef SQUARE_CHECKER_RESID_EN
    logic [ACC_W-1:0]     diffS;
    logic signed [IN_W:0] residR;
`endif

    square_core #(.ROOT_W(ROOT_W)) uCore (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (loadS),
        .step   (stepS),
        .rootIn (bus.rootIn),
        .acc    (accS),
        .last   (lastS)
    );

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        nextStateS = stateR;
        loadS      = 1'b0;
        stepS      = 1'b0;
        case (stateR)
            IDLE: begin
                if (bus.start) begin
                    loadS      = 1'b1;
                    nextStateS = SQUARE;
                end else begin
                    nextStateS = IDLE;
                end
            end
            SQUARE: begin
                stepS = 1'b1;
                if (lastS) begin
                    nextStateS = CHECK;
                end else begin
                    nextStateS = SQUARE;
                end
            end
            CHECK:   nextStateS = DONE;
            DONE:    nextStateS = IDLE;
            default: nextStateS = IDLE;
        endcase
    end

    // Capture the request operands when a start is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valR  <= '0;
            rootR <= '0;
        end else if (loadS) begin
            valR  <= bus.valIn;
            rootR <= bus.rootIn;
        end
    end

    // Compare r^2 and (r+1)^2 against the radicand; nxt is two bits wider
    // than the square so (2^ROOT_W)^2 does not wrap.
    always_comb begin
        valExtS = {{(ACC_W-IN_W){1'b0}}, valR};
        nxtS    = accS + {{(ACC_W-ROOT_W-1){1'b0}}, rootR, 1'b0} + ACC_W'(1);
        flagsS  = packFlags(accS == valExtS,
                            (accS <= valExtS) && (nxtS > valExtS),
                            nxtS <= valExtS,
                            accS > valExtS);
    end

    // Handshake and result registers; results update only leaving CHECK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            squareR <= '0;
            flagsR  <= '0;
        end else begin
            busyR <= (nextStateS != IDLE);
            doneR <= (nextStateS == DONE);
            if (stateR == CHECK) begin
                squareR <= accS[2*ROOT_W-1:0];
                flagsR  <= flagsS;
            end
        end
    end

`ifdef SQUARE_CHECKER_RESID_EN
    // Two's-complement residual valIn - root^2, kept to IN_W+1 bits.
    always_comb begin
        diffS = valExtS - accS;
    end

    // Residual register, loaded alongside the flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            residR <= '0;
        end else if (stateR == CHECK) begin
            residR <= $signed(diffS[IN_W:0]);
        end
    end

    assign bus.resid = residR;
`endif

    assign bus.busy    = busyR;
    assign bus.done    = doneR;
    assign bus.square  = squareR;
    assign bus.isExact = flagsR[FLAG_EXACT];
    assign bus.isFloor = flagsR[FLAG_FLOOR];
    assign bus.tooLow  = flagsR[FLAG_LOW];
    assign bus.tooHigh = flagsR[FLAG_HIGH];

endmodule

// File: tb/tb_square_checker.sv
// Self-checking bench for square_checker: table vectors, hand-written
// multi-cycle sequences and a full root sweep, all checked by a scoreboard.
module tb_square_checker;
    import sqrt_pkg::*;

    localparam int IN_W   = IN_W_DEF;
    localparam int ROOT_W = ROOT_W_DEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    square_checker_if #(.IN_W(IN_W), .ROOT_W(ROOT_W)) sqIf();

    square_checker #(.IN_W(IN_W), .ROOT_W(ROOT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sqIf.slave)
    );

    typedef struct {
        logic [19:0]        sq;
        logic               exact;
        logic               floorOk;
        logic               low;
        logic               high;
        logic signed [20:0] resid;
    } expRes_t;

    typedef struct {
        logic [19:0] val;
        logic [9:0]  root;
        expRes_t     e;
    } vec_t;

    expRes_t sbQ[$];
    int nChecks   = 0;
    int nPass     = 0;
    int doneCount = 0;
    int lastDoneCyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic expRes_t model(input int unsigned val, input int unsigned root);
        expRes_t m;
        int unsigned sq;
        int unsigned nx;
        int          d;
        sq        = root * root;
        nx        = (root + 1) * (root + 1);
        d         = int'(val) - int'(sq);
        m.sq      = sq[19:0];
        m.exact   = (sq == val);
        m.high    = (sq > val);
        m.low     = (nx <= val);
        m.floorOk = !m.high && !m.low;
        m.resid   = d[20:0];
        return m;
    endfunction

    // Scoreboard: every done pops one expected result and compares it.
    always @(negedge clk) begin
        if (sqIf.done === 1'b1) begin
            expRes_t e;
            doneCount++;
            lastDoneCyc = cyc;
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("FAIL unexpected_done: got done=1 with nothing pending, expected done=0");
            end else begin
                e = sbQ.pop_front();
                check("square",  32'(sqIf.square),  32'(e.sq));
                check("isExact", 32'(sqIf.isExact), 32'(e.exact));
                check("isFloor", 32'(sqIf.isFloor), 32'(e.floorOk));
                check("tooLow",  32'(sqIf.tooLow),  32'(e.low));
                check("tooHigh", 32'(sqIf.tooHigh), 32'(e.high));
                check("onehot",  32'(sqIf.tooLow) + 32'(sqIf.tooHigh) + 32'(sqIf.isFloor), 32'd1);
                check("exact_implies_floor", 32'(!sqIf.isExact || sqIf.isFloor), 32'd1);
`ifdef SQUARE_CHECKER_RESID_EN
                check("resid", 32'(sqIf.resid), 32'(e.resid));
`endif
            end
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"},   32'(sqIf.busy),   32'd0);
        check({tag, "_done"},   32'(sqIf.done),   32'd0);
        check({tag, "_square"}, 32'(sqIf.square), 32'd0);
        check({tag, "_flags"},  32'({sqIf.isExact, sqIf.isFloor, sqIf.tooLow, sqIf.tooHigh}), 32'd0);
`ifdef SQUARE_CHECKER_RESID_EN
        check({tag, "_resid"},  32'(sqIf.resid),  32'd0);
`endif
    endtask

    // Entered just after a rising edge with the DUT idle; leaves at the start
    // of the cycle after done so the next call is back-to-back.
    task automatic runOp(input logic [19:0] val, input logic [9:0] root,
                         input expRes_t e, output int doneAt);
        int  k;
        bit  found;
        sqIf.valIn  = val;
        sqIf.rootIn = root;
        sqIf.start  = 1'b1;
        sbQ.push_back(e);
        @(posedge clk); #1;
        sqIf.start = 1'b0;
        k     = 1;
        found = 1'b0;
        while (k <= 40 && !found) begin
            @(negedge clk);
            if (k == 1) check("busy_cycle1", 32'(sqIf.busy), 32'd1);
            if (sqIf.done === 1'b1) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        doneAt = cyc;
        check("latency", 32'(k), 32'd12);
        if (!found) sbQ.delete();
        @(posedge clk); #1;
        check("busy_after_done", 32'(sqIf.busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by 900000ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t    vecs[10];
        int      d1;
        int      d2;
        int      dc;
        expRes_t e;

        vecs[0] = '{20'd100,     10'd10,   '{20'd100,     1'b1, 1'b1, 1'b0, 1'b0, 21'sd0}};
        vecs[1] = '{20'd99,      10'd9,    '{20'd81,      1'b0, 1'b1, 1'b0, 1'b0, 21'sd18}};
        vecs[2] = '{20'd99,      10'd10,   '{20'd100,     1'b0, 1'b0, 1'b0, 1'b1, -21'sd1}};
        vecs[3] = '{20'd1048575, 10'd1023, '{20'd1046529, 1'b0, 1'b1, 1'b0, 1'b0, 21'sd2046}};
        vecs[4] = '{20'd0,       10'd0,    '{20'd0,       1'b1, 1'b1, 1'b0, 1'b0, 21'sd0}};
        vecs[5] = '{20'd50,      10'd3,    '{20'd9,       1'b0, 1'b0, 1'b1, 1'b0, 21'sd41}};
        vecs[6] = '{20'd1048575, 10'd0,    '{20'd0,       1'b0, 1'b0, 1'b1, 1'b0, 21'sd1048575}};
        vecs[7] = '{20'd0,       10'd1023, '{20'd1046529, 1'b0, 1'b0, 1'b0, 1'b1, -21'sd1046529}};
        vecs[8] = '{20'd24,      10'd5,    '{20'd25,      1'b0, 1'b0, 1'b0, 1'b1, -21'sd1}};
        vecs[9] = '{20'd35,      10'd5,    '{20'd25,      1'b0, 1'b1, 1'b0, 1'b0, 21'sd10}};

        sqIf.start  = 1'b0;
        sqIf.valIn  = '0;
        sqIf.rootIn = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].val, vecs[i].root, vecs[i].e, dc);
            if (i == 0) d1 = dc;
            if (i == 1) d2 = dc;
        end
        check("back_to_back_spacing", 32'(d2 - d1), 32'd13);

        // Starts at cycles 3 and 11 of a busy operation are ignored.
        sqIf.valIn  = 20'd50;
        sqIf.rootIn = 10'd3;
        sqIf.start  = 1'b1;
        sbQ.push_back(vecs[5].e);
        dc = doneCount;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            sqIf.start = (k == 3 || k == 11);
            if (k == 3 || k == 11) begin
                sqIf.valIn  = 20'd7;
                sqIf.rootIn = 10'd2;
            end
            @(negedge clk);
            if (k == 12) check("ignored_done_at_12", 32'(sqIf.done), 32'd1);
            @(posedge clk); #1;
        end
        sqIf.start = 1'b0;
        check("ignored_single_done", 32'(doneCount - dc), 32'd1);
        check("ignored_square_held", 32'(sqIf.square), 32'd9);
        check("ignored_low_held",    32'(sqIf.tooLow), 32'd1);
        check("ignored_not_busy",    32'(sqIf.busy),   32'd0);

        // Reset in cycle 5 of an operation, with a start in the reset cycle.
        sqIf.valIn  = 20'd400;
        sqIf.rootIn = 10'd20;
        sqIf.start  = 1'b1;
        sbQ.push_back(model(400, 20));
        dc = doneCount;
        @(posedge clk); #1;
        sqIf.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n       = 1'b0;
        sqIf.start  = 1'b1;
        sqIf.valIn  = 20'd1;
        sqIf.rootIn = 10'd1;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        sqIf.start = 1'b0;
        sbQ.delete();
        @(negedge clk);
        checkAllZero("midreset");
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", 32'(doneCount - dc), 32'd0);
        check("midreset_idle",    32'(sqIf.busy),      32'd0);
        e = '{20'd144, 1'b1, 1'b1, 1'b0, 1'b0, 21'sd0};
        runOp(20'd144, 10'd12, e, dc);

        // Sweep every root at valIn = r^2 and r^2 - 1.
        for (int r = 0; r < 1024; r++) begin
            int unsigned sq;
            sq = r * r;
            runOp(sq[19:0], 10'(r), model(sq, r), dc);
            if (r > 0) runOp(20'(sq - 1), 10'(r), model(sq - 1, r), dc);
        end

        check("queue_drained", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
